// File: rtl/k68_sasc_pkg.sv
// Shared types and constants for the k68 SASC sequencer/arbiter.
package k68_sasc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAITF,
        ST_ACC,
        ST_ACK
    } state_t;

    localparam logic [7:0]  DIV0_DEF     = 8'd1;
    localparam logic [7:0]  DIV1_DEF     = 8'd217;
    localparam logic [15:0] WAIT_MAX_DEF = 16'd4095;

    // Field positions in sasc_dat_i = {full, empty, rx byte}
    localparam int FULL_BIT  = 9;
    localparam int EMPTY_BIT = 8;

endpackage

// File: rtl/k68_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, `last` winner
// register updated by a strobe from the sequencer.
module k68_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] grant
);

    logic last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last <= 1'b1;
        else if (upd)
            last <= upd_id;
    end

    // On a tie the requester that was not served last wins
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/k68_sasc_ctl.sv
// Sequencer and round-robin arbiter sharing the SASC byte port between two
// requesters. Optional RX-not-empty interrupt flop: define K68_SASC_CTL_IRQ_EN.
//
// state    | meaning
// IDLE     | waiting for any request
// ARB      | pick winner, latch id/we/dat
// WAITF    | write stalled on TX FIFO full, bounded by WAIT_MAX
// ACC      | one-cycle SASC access
// ACK      | ack pulse to the winner, qualifiers valid
module k68_sasc_ctl
    import k68_sasc_pkg::*;
#(
    parameter logic [7:0]  DIV0     = DIV0_DEF,
    parameter logic [7:0]  DIV1     = DIV1_DEF,
    parameter logic [15:0] WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [7:0]  dat0_i,
    input  logic [7:0]  dat1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [7:0]  rdat_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        sasc_cs_o,
    output logic        sasc_we_o,
    output logic [23:0] sasc_dat_o,
    input  logic [9:0]  sasc_dat_i,
    output logic        irq_o
);

    state_t      state, state_nx;
    logic [1:0]  grant;
    logic        win_q, we_q, rvalid_q, err_q;
    logic [7:0]  dat_q, rdat_q;
    logic [15:0] cnt;
    logic        full, empty, sel_we, last_wait;

    assign full      = sasc_dat_i[FULL_BIT];
    assign empty     = sasc_dat_i[EMPTY_BIT];
    assign sel_we    = grant[1] ? we1_i : we0_i;
    assign last_wait = (cnt == WAIT_MAX - 16'd1);

    k68_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    ({req1_i, req0_i}),
        .upd    (state == ST_ACK),
        .upd_id (win_q),
        .grant  (grant)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            dat_q    <= 8'h00;
            rdat_q   <= 8'h00;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= 16'd0;
        end else begin
            state <= state_nx;
            case (state)
                ST_ARB: begin
                    win_q    <= grant[1];
                    we_q     <= sel_we;
                    dat_q    <= grant[1] ? dat1_i : dat0_i;
                    rdat_q   <= 8'h00;
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    cnt      <= 16'd0;
                end
                ST_WAITF: begin
                    cnt <= cnt + 16'd1;
                    if (full && last_wait)
                        err_q <= 1'b1;
                end
                ST_ACC: begin
                    if (!we_q && !empty) begin
                        rdat_q   <= sasc_dat_i[7:0];
                        rvalid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (req0_i || req1_i) state_nx = ST_ARB;
            ST_ARB: begin
                if (grant == 2'b00)
                    state_nx = ST_IDLE;
                else if (sel_we && full)
                    state_nx = ST_WAITF;
                else
                    state_nx = ST_ACC;
            end
            ST_WAITF: begin
                if (!full)
                    state_nx = ST_ACC;
                else if (last_wait)
                    state_nx = ST_ACK;
            end
            ST_ACC:   state_nx = ST_ACK;
            ST_ACK:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Outputs decode from the state register so an async reset clears them at once
    always_comb begin
        ack0_o     = 1'b0;
        ack1_o     = 1'b0;
        rdat_o     = 8'h00;
        rvalid_o   = 1'b0;
        err_o      = 1'b0;
        sasc_cs_o  = 1'b0;
        sasc_we_o  = 1'b0;
        sasc_dat_o = {DIV1, DIV0, 8'h00};
        if (state == ST_ACC) begin
            sasc_cs_o = we_q || !empty;
            sasc_we_o = we_q;
        end
        if (state == ST_ACK) begin
            ack0_o   = !win_q;
            ack1_o   = win_q;
            rdat_o   = rdat_q;
            rvalid_o = rvalid_q;
            err_o    = err_q;
        end
        if (state == ST_WAITF || state == ST_ACC || state == ST_ACK)
            sasc_dat_o[7:0] = dat_q;
    end

`ifdef K68_SASC_CTL_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            irq_q <= 1'b0;
        else
            irq_q <= ~empty;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_k68_sasc_ctl.sv
// Randomized self-checking bench for k68_sasc_ctl against a transaction-level model.
module tb_k68_sasc_ctl;

    localparam int WMAX = 12;
    localparam logic [15:0] DIVS = 16'hD901;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
    logic [7:0]  dat0_i = 8'h00, dat1_i = 8'h00;
    logic        ack0_o, ack1_o, rvalid_o, err_o, sasc_cs_o, sasc_we_o, irq_o;
    logic [7:0]  rdat_o;
    logic [23:0] sasc_dat_o;
    logic [9:0]  sasc_dat_i = 10'h100;

    int n_chk  = 0;
    int n_pass = 0;
    int m_last = 1;
    logic irq_model;

    k68_sasc_ctl #(.WAIT_MAX(16'(WMAX))) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .dat0_i(dat0_i), .dat1_i(dat1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .rdat_o(rdat_o),
        .rvalid_o(rvalid_o), .err_o(err_o),
        .sasc_cs_o(sasc_cs_o), .sasc_we_o(sasc_we_o),
        .sasc_dat_o(sasc_dat_o), .sasc_dat_i(sasc_dat_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Interrupt reference: registered RX-not-empty
    always @(posedge clk_i or posedge rst_i)
        if (rst_i) irq_model <= 1'b0;
        else       irq_model <= ~sasc_dat_i[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One transaction from its IDLE cycle (c=0). Full is high for cycles c < 1+len.
    task automatic do_txn(input bit drop, input int len, input bit emp, input logic [7:0] rx);
        int w, exp_acc, exp_ack, exp_cs, cs_n, cs_c, ack_c;
        bit twe, tmo, cs_we, a_rv, a_err;
        logic [7:0] tdat, a_rdat;
        logic [1:0] a_id;
        logic [23:0] cs_dat;
        w    = (req0_i && req1_i) ? (m_last == 1 ? 0 : 1) : (req0_i ? 0 : 1);
        twe  = (w == 1) ? we1_i : we0_i;
        tdat = (w == 1) ? dat1_i : dat0_i;
        tmo  = twe && (len > WMAX);
        exp_acc = twe ? 2 + len : 2;
        exp_ack = tmo ? WMAX + 2 : exp_acc + 1;
        exp_cs  = (tmo || (!twe && emp)) ? 0 : 1;
        cs_n = 0; cs_c = -1; ack_c = -1;
        cs_we = 0; cs_dat = '0; a_rdat = '0; a_rv = 0; a_err = 0; a_id = '0;
        for (int c = 0; c < 80 && ack_c < 0; c++) begin
            @(negedge clk_i);
            sasc_dat_i = {(c < 1 + len), emp, rx};
            #1;
`ifdef K68_SASC_CTL_IRQ_EN
            chk("irq", irq_o, irq_model);
`else
            chk("irq", irq_o, 1'b0);
`endif
            if (sasc_cs_o) begin
                cs_n++; cs_c = c; cs_we = sasc_we_o; cs_dat = sasc_dat_o;
            end
            if (ack0_o || ack1_o) begin
                ack_c = c; a_id = {ack1_o, ack0_o};
                a_rdat = rdat_o; a_rv = rvalid_o; a_err = err_o;
            end else begin
                chk("qual_idle", {rdat_o, rvalid_o, err_o}, 10'h000);
            end
            if (c == 2) begin
                if (w == 1) dat1_i = 8'($urandom);
                else        dat0_i = 8'($urandom);
            end
        end
        chk("ack_cyc", ack_c, exp_ack);
        chk("ack_id", a_id, (w == 1) ? 2'b10 : 2'b01);
        chk("cs_cnt", cs_n, exp_cs);
        if (exp_cs == 1) begin
            chk("cs_cyc", cs_c, exp_acc);
            chk("cs_we", cs_we, twe);
            chk("cs_dat", cs_dat, {DIVS, tdat});
        end
        chk("rdat", a_rdat, (!twe && !emp) ? rx : 8'h00);
        chk("rvalid", a_rv, !twe && !emp);
        chk("err", a_err, tmo);
        m_last = w;
        if (drop) begin
            if (w == 1) req1_i = 1'b0;
            else        req0_i = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {ack0_o, ack1_o, sasc_cs_o, sasc_we_o, rdat_o, rvalid_o, err_o, irq_o}, 15'h0);
        chk({tag, "_dat"}, sasc_dat_o, {DIVS, 8'h00});
    endtask

    initial begin
        int r, sel, len;
        #1;
        chk_quiet("reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Tie held for four transactions: alternate starting with requester 0
        req0_i = 1'b1; we0_i = 1'b1; dat0_i = 8'h11;
        req1_i = 1'b1; we1_i = 1'b0; dat1_i = 8'h22;
        for (int i = 0; i < 4; i++) begin
            r = m_last;
            do_txn(1'b0, 0, 1'b0, 8'h40 + 8'(i));
            chk("rr_alt", m_last, (i % 2 == 0) ? 0 : 1);
            chk("rr_flip", m_last != r, 1'b1);
        end
        req0_i = 1'b0; req1_i = 1'b0;

        req0_i = 1'b1; we0_i = 1'b1; dat0_i = 8'hA5;
        do_txn(1'b1, 0, 1'b1, 8'h00);
        req1_i = 1'b1; we1_i = 1'b0;
        do_txn(1'b1, 0, 1'b0, 8'h3C);
        req1_i = 1'b1;
        do_txn(1'b1, 0, 1'b1, 8'h3C);
        req0_i = 1'b1; we0_i = 1'b1; dat0_i = 8'h5E;
        do_txn(1'b1, 10, 1'b0, 8'h00);
        req0_i = 1'b1; dat0_i = 8'h6F;
        do_txn(1'b1, WMAX, 1'b0, 8'h00);
        req1_i = 1'b1; we1_i = 1'b1; dat1_i = 8'h7A;
        do_txn(1'b1, 40, 1'b0, 8'h00);

        // Reset in the ACC cycle
        req0_i = 1'b1; we0_i = 1'b1; dat0_i = 8'h5A;
        sasc_dat_i = 10'h100;
        repeat (3) @(negedge clk_i);
        #1;
        chk("pre_rst_cs", sasc_cs_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk_quiet("rst_acc");
        req0_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i); #1;
            chk_quiet("rst_hold");
        end
        rst_i = 1'b0;
        m_last = 1;
        @(posedge clk_i); #1;
        req0_i = 1'b1; we0_i = 1'b0;
        do_txn(1'b1, 0, 1'b0, 8'h77);

        for (int i = 0; i < 80; i++) begin
            if (!req0_i && !req1_i) begin
                r = $urandom_range(1, 3);
                if (r[0]) begin req0_i = 1'b1; we0_i = 1'($urandom); dat0_i = 8'($urandom); end
                if (r[1]) begin req1_i = 1'b1; we1_i = 1'($urandom); dat1_i = 8'($urandom); end
            end
            sel = $urandom_range(0, 9);
            if (sel < 6)      len = 0;
            else if (sel < 9) len = $urandom_range(1, WMAX);
            else              len = WMAX + $urandom_range(1, 4);
            do_txn(1'b1, len, 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
